entity_mover: RTL and testbench



---
 rtl/pacman_pkg.sv | 25 ++
 rtl/pos_step.sv | 41 ++++
 rtl/entity_mover.sv | 156 +++++++++++++++
 tb/tb_entity_mover.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared maze types: directions, mover states,
// maze geometry and entity codes.
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    LEFT  = 2'b01,
    DOWN  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHK_NEW,
    S_CHK_CUR
  } mv_state_t;

  localparam int SPRITE_SIZE = 14;
  localparam int MAZE_W      = 256;
  localparam int MAZE_H      = 248;

  localparam logic [1:0] PACMAN = 2'd1;
  localparam logic [1:0] GHOST  = 2'd3;

endpackage

// File: rtl/pos_step.sv
// One-step position update: horizontal tunnel
// wrap, vertical clamp to the maze edges.
module pos_step
  import pacman_pkg::*;
#(
  parameter logic [9:0] STEP  = 10'd1,
  parameter logic [9:0] X_MAX = 10'd242,
  parameter logic [9:0] Y_MAX = 10'd234
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] dir,
  output logic [9:0] nx,
  output logic [9:0] ny
);

  logic [10:0] sum_x;
  logic [10:0] sum_y;

  assign sum_x = {1'b0, x} + {1'b0, STEP};
  assign sum_y = {1'b0, y} + {1'b0, STEP};

  // Only the axis of travel changes.
  always_comb begin
    nx = x;
    ny = y;
    unique case (dir_t'(dir))
      UP:
        ny = (y < STEP) ? 10'd0 : y - STEP;
      DOWN:
        ny = (sum_y > {1'b0, Y_MAX}) ?
             Y_MAX : sum_y[9:0];
      LEFT:
        nx = (x < STEP) ? X_MAX : x - STEP;
      RIGHT:
        nx = (sum_x > {1'b0, X_MAX}) ?
             10'd0 : sum_x[9:0];
    endcase
  end

endmodule

// File: rtl/entity_mover.sv
// Per-frame mover: queries walls with the wanted
// direction, falls back to the current one.
module entity_mover
  import pacman_pkg::*;
#(
  parameter logic [9:0] START_X = 10'd120,
  parameter logic [9:0] START_Y = 10'd180,
  parameter logic [9:0] X_MAX   = 10'd242,
  parameter logic [9:0] Y_MAX   = 10'd234,
  parameter logic [9:0] STEP    = 10'd1,
  parameter int         CHECK_LAT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       req_valid,
  input  logic [1:0] req_dir,
  input  logic       allowed,
  output logic [9:0] entityX,
  output logic [9:0] entityY,
  output logic [1:0] direction,
  output logic       moving,
  output logic       busy
);

  localparam int CW = (CHECK_LAT < 2) ?
    1 : $clog2(CHECK_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(CHECK_LAT);

  mv_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  dir_t          cur_q, cur_d;
  dir_t          pend_q, pend_d;
  dir_t          try_q, try_d;
  dir_t          dir_q, dir_d;
  logic          mov_q, mov_d;
  logic          busy_q, busy_d;
  logic [9:0]    nx, ny;

  // dir_q is always the direction under query,
  // so it is also the direction to step in.
  pos_step #(
    .STEP  (STEP),
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_step (
    .x   (x_q),
    .y   (y_q),
    .dir (dir_q),
    .nx  (nx),
    .ny  (ny)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    try_d   = try_q;
    dir_d   = dir_q;
    mov_d   = mov_q;
    busy_d  = busy_q;
    if (req_valid)
      pend_d = dir_t'(req_dir);
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          try_d   = req_valid ?
                    dir_t'(req_dir) : pend_q;
          dir_d   = try_d;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CHK_NEW;
        end
      end
      S_CHK_NEW: begin
        if (cnt_q == LAT) begin
          if (allowed) begin
            cur_d   = try_q;
            x_d     = nx;
            y_d     = ny;
            mov_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (try_q == cur_q) begin
            mov_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            dir_d   = cur_q;
            state_d = S_CHK_CUR;
          end
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      S_CHK_CUR: begin
        if (cnt_q == LAT) begin
          if (allowed) begin
            x_d = nx;
            y_d = ny;
          end
          mov_d   = allowed;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        dir_d   = cur_q;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= START_X;
      y_q     <= START_Y;
      cur_q   <= LEFT;
      pend_q  <= LEFT;
      try_q   <= LEFT;
      dir_q   <= LEFT;
      mov_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      try_q   <= try_d;
      dir_q   <= dir_d;
      mov_q   <= mov_d;
      busy_q  <= busy_d;
    end
  end

  assign entityX   = x_q;
  assign entityY   = y_q;
  assign direction = dir_q;
  assign moving    = mov_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_entity_mover.sv
// Scoreboard bench for entity_mover: a reference
// model queues each frame's expected outcome.
module tb_entity_mover;
  import pacman_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick;
  logic       req_valid;
  logic [1:0] req_dir;
  logic       allowed;
  logic [9:0] entityX;
  logic [9:0] entityY;
  logic [1:0] direction;
  logic       moving;
  logic       busy;

  entity_mover dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .req_valid  (req_valid),
    .req_dir    (req_dir),
    .allowed    (allowed),
    .entityX    (entityX),
    .entityY    (entityY),
    .direction  (direction),
    .moving     (moving),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] dir;
    logic       mv;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  logic [9:0] m_x, m_y;
  logic [1:0] m_cur, m_pend;

  task automatic model_reset();
    m_x    = 10'd120;
    m_y    = 10'd180;
    m_cur  = 2'b01;
    m_pend = 2'b01;
    sb.delete();
  endtask

  task automatic mstep(input logic [1:0] d);
    case (d)
      2'b00: m_y = (m_y == 0) ? 10'd0 : m_y - 1;
      2'b10: m_y = (m_y >= 234) ? 10'd234 : m_y + 1;
      2'b01: m_x = (m_x == 0) ? 10'd242 : m_x - 1;
      default:
        m_x = (m_x >= 242) ? 10'd0 : m_x + 1;
    endcase
  endtask

  task automatic run_frame(
    input logic       rv,
    input logic [1:0] rq,
    input logic       a_new,
    input logic       a_cur,
    input logic       drop_tick,
    input logic       mid_rv,
    input logic [1:0] mid_dir
  );
    logic [1:0] tdir, old_cur, qdir;
    logic [9:0] ox, oy;
    exp_t e;
    int cyc;
    bit done;
    tdir    = rv ? rq : m_pend;
    if (rv) m_pend = rq;
    old_cur = m_cur;
    ox      = m_x;
    oy      = m_y;
    if (a_new) begin
      m_cur = tdir;
      mstep(tdir);
      e.mv = 1'b1; e.lat = 4;
    end else if (tdir == m_cur) begin
      e.mv = 1'b0; e.lat = 4;
    end else begin
      e.lat = 7;
      e.mv  = a_cur;
      if (a_cur) mstep(m_cur);
    end
    e.x = m_x; e.y = m_y; e.dir = m_cur;
    sb.push_back(e);
    if (mid_rv) m_pend = mid_dir;

    @(posedge Clk); #1;
    frame_tick = 1'b1;
    req_valid  = rv;
    req_dir    = rq;
    allowed    = a_new;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    req_valid  = 1'b0;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 20) begin
      if (busy) begin
        qdir = (cyc <= 3) ? tdir : old_cur;
        n_chk++;
        if (direction !== qdir ||
            entityX !== ox || entityY !== oy) begin
          $display("FAIL query c%0d: d=%0d x=%0d y=%0d exp d=%0d x=%0d y=%0d",
                   cyc, direction, entityX, entityY,
                   qdir, ox, oy);
          n_fail++;
        end
        if (cyc == 2) begin
          if (drop_tick) frame_tick = 1'b1;
          if (mid_rv) begin
            req_valid = 1'b1;
            req_dir   = mid_dir;
          end
        end
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        req_valid  = 1'b0;
        cyc++;
        if (cyc == 4) allowed = a_cur;
      end else begin
        done = 1'b1;
      end
    end
    allowed = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL timeout: busy stuck after %0d cycles",
               cyc);
      n_fail++;
    end
    e = sb.pop_front();
    n_chk++;
    if (cyc !== e.lat) begin
      $display("FAIL latency: got T+%0d exp T+%0d",
               cyc, e.lat);
      n_fail++;
    end
    n_chk++;
    if (entityX !== e.x || entityY !== e.y) begin
      $display("FAIL pos: got %0d,%0d exp %0d,%0d",
               entityX, entityY, e.x, e.y);
      n_fail++;
    end
    n_chk++;
    if (direction !== e.dir || moving !== e.mv) begin
      $display("FAIL dir/moving: got %0d/%0d exp %0d/%0d",
               direction, moving, e.dir, e.mv);
      n_fail++;
    end
    if (drop_tick) begin
      @(posedge Clk); #1;
      n_chk++;
      if (busy !== 1'b0) begin
        $display("FAIL dropped tick: busy=%0d exp 0",
                 busy);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset();
    Reset_n    = 1'b0;
    frame_tick = 1'b0;
    req_valid  = 1'b0;
    req_dir    = 2'b00;
    allowed    = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    model_reset();
    n_chk++;
    if (entityX !== 10'd120 || entityY !== 10'd180) begin
      $display("FAIL reset pos: got %0d,%0d exp 120,180",
               entityX, entityY);
      n_fail++;
    end
    n_chk++;
    if (direction !== 2'b01) begin
      $display("FAIL reset dir: got %0d exp 1",
               direction);
      n_fail++;
    end
    n_chk++;
    if (moving !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset flags: moving=%0d busy=%0d exp 0,0",
               moving, busy);
      n_fail++;
    end
  endtask

  task automatic test_default_move();
    run_frame(1'b0, 2'b00, 1'b1, 1'b1,
              1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_fallback();
    @(posedge Clk); #1;
    req_valid = 1'b1;
    req_dir   = 2'b00;
    m_pend    = 2'b00;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    run_frame(1'b0, 2'b00, 1'b0, 1'b1,
              1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_new_accept();
    run_frame(1'b0, 2'b00, 1'b1, 1'b1,
              1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_both_reject();
    run_frame(1'b1, 2'b11, 1'b0, 1'b0,
              1'b1, 1'b0, 2'b00);
  endtask

  task automatic test_busy_req();
    run_frame(1'b1, 2'b01, 1'b1, 1'b1,
              1'b0, 1'b1, 2'b10);
    run_frame(1'b0, 2'b00, 1'b1, 1'b1,
              1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 300 && m_x != 0; i++)
      run_frame(1'b1, 2'b01, 1'b1, 1'b1,
                1'b0, 1'b0, 2'b00);
    run_frame(1'b1, 2'b01, 1'b1, 1'b1,
              1'b0, 1'b0, 2'b00);
    run_frame(1'b1, 2'b11, 1'b1, 1'b1,
              1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_clamp_up();
    for (int i = 0; i < 300 && m_y != 0; i++)
      run_frame(1'b1, 2'b00, 1'b1, 1'b1,
                1'b0, 1'b0, 2'b00);
    run_frame(1'b1, 2'b00, 1'b1, 1'b1,
              1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_reset_mid();
    @(posedge Clk); #1;
    frame_tick = 1'b1;
    req_valid  = 1'b1;
    req_dir    = 2'b11;
    allowed    = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    req_valid  = 1'b0;
    @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (entityX !== 10'd120 || entityY !== 10'd180 ||
        direction !== 2'b01) begin
      $display("FAIL async reset: got %0d,%0d,%0d exp 120,180,1",
               entityX, entityY, direction);
      n_fail++;
    end
    n_chk++;
    if (busy !== 1'b0 || moving !== 1'b0) begin
      $display("FAIL async reset flags: busy=%0d moving=%0d exp 0,0",
               busy, moving);
      n_fail++;
    end
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    allowed = 1'b0;
    n_chk++;
    if (entityX !== 10'd120 || busy !== 1'b0) begin
      $display("FAIL post reset: x=%0d busy=%0d exp 120,0",
               entityX, busy);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_default_move();
    test_fallback();
    test_new_accept();
    test_both_reject();
    test_busy_req();
    test_wrap();
    test_clamp_up();
    test_reset_mid();
    test_default_move();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
